// File: rtl/perint_pkg.sv
// PerInt op encodings, controller command codes and result constants shared by interrupt agents.
// Results are returned 64 bits wide; callers keep the low ARCHBITSZ bits.
package perint_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  localparam logic [1:0] CMDACKINT = 2'b00;
  localparam logic [1:0] CMDINTDST = 2'b01;
  localparam logic [1:0] CMDENAINT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACKREQ  = 3'd1,
    ST_ACKRES  = 3'd2,
    ST_IPIREQ  = 3'd3,
    ST_IPIRES  = 3'd4,
    ST_IPIWAIT = 3'd5
  } intdst_state_t;

  // -1 at the given width
  function automatic logic [63:0] res_invalid(input int unsigned width);
    logic [63:0] v;
    v = '1;
    if (width < 64) v = (64'd1 << width) - 64'd1;
    return v;
  endfunction

  // -2 at the given width
  function automatic logic [63:0] res_busy(input int unsigned width);
    return res_invalid(width) & ~64'd1;
  endfunction

endpackage

// File: rtl/intdst_fifo.sv
// Synchronous FIFO of source indices; head and valid come straight from registers.
// Push and pop in one cycle are both honoured; pop while empty and push while full are dropped.
module intdst_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_head_vld,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign w_pop      = i_pop && (r_cnt != '0);
  assign w_push     = i_push && ((r_cnt != CNT_FULL) || w_pop);
  assign o_full     = (r_cnt == CNT_FULL);
  assign o_head_vld = (r_cnt != '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/intdst_agent.sv
// Destination interrupt agent: acks controller requests over PerInt, queues indices, sends/retries IPIs.
// Ack to queued index is 3 cycles with pi1_rdy_i high; bus ops hold while pi1_rdy_i is low, requests defer while the queue is full.
module intdst_agent
  import perint_pkg::*;
#(
  parameter int ARCHBITSZ   = 16,
  parameter int ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  parameter int INTCTRLADDR = 0,
  parameter int DSTIDX      = 0,
  parameter int FIFODEPTH   = 4,
  parameter int RETRYDLY    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  input  logic                   pi1_rdy_i,
  input  logic                   intrqst_i,
  output logic                   intrdy_o,
  output logic                   intbest_o,
  input  logic                   enable_i,
  input  logic                   halted_i,
  output logic                   irq_valid_o,
  output logic [ARCHBITSZ-1:0]   irq_idx_o,
  input  logic                   irq_ready_i,
  input  logic                   ipi_req_i,
  input  logic [ARCHBITSZ-3:0]   ipi_dst_i,
  output logic                   ipi_busy_o,
  output logic                   ipi_done_o,
  output logic                   ipi_err_o
);

  localparam int CW = $clog2(RETRYDLY + 1);
  localparam logic [63:0]          RES_INV64 = res_invalid(ARCHBITSZ);
  localparam logic [63:0]          RES_BSY64 = res_busy(ARCHBITSZ);
  localparam logic [ARCHBITSZ-1:0] RES_INV   = RES_INV64[ARCHBITSZ-1:0];
  localparam logic [ARCHBITSZ-1:0] RES_BSY   = RES_BSY64[ARCHBITSZ-1:0];
  localparam logic [ARCHBITSZ-4:0] DST_SELF  = (ARCHBITSZ-3)'(DSTIDX);

  intdst_state_t        r_state;
  intdst_state_t        w_nxt_state;
  logic                 r_ipi_busy;
  logic [ARCHBITSZ-3:0] r_ipi_dst;
  logic                 r_ipi_done;
  logic                 r_ipi_err;
  logic [CW-1:0]        r_retry_cnt;

  logic w_fifo_full;
  logic w_fifo_push;
  logic w_ipi_new;
  logic w_ipi_pend;
  logic w_res_busy;
  logic w_res_inv;

  assign w_res_busy  = (pi1_data_i == RES_BSY);
  assign w_res_inv   = (pi1_data_i == RES_INV);
  assign w_ipi_new   = ipi_req_i && !r_ipi_busy;
  // A fresh request is served from IDLE in the cycle it is sampled, matching the ack latency.
  assign w_ipi_pend  = r_ipi_busy || w_ipi_new;
  assign w_fifo_push = (r_state == ST_ACKRES) && !w_res_busy;

  assign pi1_addr_o = ADDRBITSZ'(INTCTRLADDR);
  assign pi1_sel_o  = '1;
  assign intrdy_o   = rst_i && enable_i && !w_fifo_full && (r_state == ST_IDLE);
  assign intbest_o  = intrdy_o && halted_i;
  assign ipi_busy_o = r_ipi_busy;
  assign ipi_done_o = r_ipi_done;
  assign ipi_err_o  = r_ipi_err;

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (intrqst_i && !w_fifo_full) w_nxt_state = ST_ACKREQ;
        else if (w_ipi_pend)           w_nxt_state = ST_IPIREQ;
      end
      ST_ACKREQ:  if (pi1_rdy_i) w_nxt_state = ST_ACKRES;
      ST_ACKRES:  w_nxt_state = ST_IDLE;
      ST_IPIREQ:  if (pi1_rdy_i) w_nxt_state = ST_IPIRES;
      ST_IPIRES:  w_nxt_state = w_res_busy ? ST_IPIWAIT : ST_IDLE;
      ST_IPIWAIT: if (r_retry_cnt <= CW'(1)) w_nxt_state = ST_IDLE;
      default:    w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pi1_op_o   = PINOOP;
    pi1_data_o = '0;
    case (r_state)
      ST_ACKREQ: begin
        pi1_op_o   = PIRWOP;
        pi1_data_o = {DST_SELF, enable_i, CMDACKINT};
      end
      ST_IPIREQ: begin
        pi1_op_o   = PIRWOP;
        pi1_data_o = {r_ipi_dst, CMDINTDST};
      end
      default: begin
        pi1_op_o   = PINOOP;
        pi1_data_o = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ipi_busy  <= 1'b0;
      r_ipi_dst   <= '0;
      r_ipi_done  <= 1'b0;
      r_ipi_err   <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_ipi_done <= 1'b0;
      r_ipi_err  <= 1'b0;
      if (w_ipi_new) begin
        r_ipi_busy <= 1'b1;
        r_ipi_dst  <= ipi_dst_i;
      end
      if (r_state == ST_IPIRES) begin
        if (w_res_busy) begin
          r_retry_cnt <= CW'(RETRYDLY);
        end else begin
          r_ipi_busy <= 1'b0;
          r_ipi_done <= 1'b1;
          r_ipi_err  <= w_res_inv;
        end
      end else if ((r_state == ST_IPIWAIT) && (r_retry_cnt != '0)) begin
        r_retry_cnt <= r_retry_cnt - CW'(1);
      end
    end
  end

  intdst_fifo #(
    .WIDTH (ARCHBITSZ),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_push     (w_fifo_push),
    .i_push_dat (pi1_data_i),
    .i_pop      (irq_ready_i),
    .o_full     (w_fifo_full),
    .o_head_vld (irq_valid_o),
    .o_head_dat (irq_idx_o)
  );

endmodule

// File: tb/tb_intdst_agent.sv
// Bench for intdst_agent: a controller model answers PerInt ops from a response queue and a queue model tracks the FIFO.
module tb_intdst_agent;

  localparam int RDLY = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  pi1_op_o;
  logic [14:0] pi1_addr_o;
  logic [15:0] pi1_data_o;
  logic [1:0]  pi1_sel_o;
  logic [15:0] pi1_data_i;
  logic        pi1_rdy_i;
  logic        intrqst_i;
  logic        intrdy_o;
  logic        intbest_o;
  logic        enable_i;
  logic        halted_i;
  logic        irq_valid_o;
  logic [15:0] irq_idx_o;
  logic        irq_ready_i;
  logic        ipi_req_i;
  logic [13:0] ipi_dst_i;
  logic        ipi_busy_o;
  logic        ipi_done_o;
  logic        ipi_err_o;

  always #5 clk = ~clk;

  intdst_agent #(
    .ARCHBITSZ(16), .INTCTRLADDR(0), .DSTIDX(1), .FIFODEPTH(4), .RETRYDLY(RDLY)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o), .pi1_sel_o(pi1_sel_o),
    .pi1_data_i(pi1_data_i), .pi1_rdy_i(pi1_rdy_i),
    .intrqst_i(intrqst_i), .intrdy_o(intrdy_o), .intbest_o(intbest_o),
    .enable_i(enable_i), .halted_i(halted_i),
    .irq_valid_o(irq_valid_o), .irq_idx_o(irq_idx_o), .irq_ready_i(irq_ready_i),
    .ipi_req_i(ipi_req_i), .ipi_dst_i(ipi_dst_i),
    .ipi_busy_o(ipi_busy_o), .ipi_done_o(ipi_done_o), .ipi_err_o(ipi_err_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_q [$];
  logic [15:0] rsp_q [$];
  logic [1:0]  kind_log [$];
  int          push_due = -1;
  logic [15:0] push_val;
  int          done_due = -1;
  logic        done_err;
  int          busy_acc = -1;
  int          n_done   = 0;
  logic [13:0] cur_dst;

  logic [1:0]  s_op;
  logic [15:0] s_dat;
  logic        s_rdy, s_pop, s_rst, s_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired (cycle %0d)", name, cyc);
  endtask

  // One clock: compare at negedge, sample inputs, step the model and controller after the edge.
  task automatic tick();
    logic [15:0] res;
    @(negedge clk);
    if (rst_i) begin
      chk("irq_valid", irq_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("irq_idx", irq_idx_o, exp_q[0]);
      chk("ipi_done", ipi_done_o, cyc == done_due);
      if (cyc == done_due) chk("ipi_err", ipi_err_o, done_err);
      if (ipi_done_o) n_done++;
    end
    s_op  = pi1_op_o;
    s_dat = pi1_data_o;
    s_rdy = pi1_rdy_i;
    s_pop = irq_ready_i;
    s_rst = rst_i;
    s_en  = enable_i;
    @(posedge clk);
    #1;
    cyc++;
    pi1_data_i = 16'hA5A5;
    if (!s_rst) begin
      exp_q.delete();
      push_due = -1;
      done_due = -1;
      busy_acc = -1;
    end else begin
      if (s_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (push_due == cyc) begin
        exp_q.push_back(push_val);
        push_due = -1;
      end
      if (s_op == 2'b11 && s_rdy) begin
        res = 16'h0000;
        if (rsp_q.size() != 0) res = rsp_q.pop_front();
        else expired("rsp_underrun");
        kind_log.push_back(s_dat[1:0]);
        if (s_dat[1:0] == 2'b00) begin
          chk("ack_cmd", s_dat, {14'd1, s_en, 2'b00});
          intrqst_i = 1'b0;
          busy_acc  = -1;
          if (res != 16'hFFFE) begin
            push_due = cyc + 1;
            push_val = res;
          end
        end else begin
          chk("ipi_cmd", s_dat, {cur_dst, 2'b01});
          if (busy_acc >= 0) chk("retry_gap", cyc - busy_acc, RDLY + 3);
          if (res == 16'hFFFE) begin
            busy_acc = cyc;
          end else begin
            busy_acc = -1;
            done_due = cyc + 1;
            done_err = (res == 16'hFFFF);
          end
        end
        pi1_data_i = res;
      end
    end
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 30 && intrqst_i; i++) tick();
    if (intrqst_i) expired("ack_wait");
    tick();
    tick();
  endtask

  task automatic do_ack(input logic [15:0] val);
    rsp_q.push_back(val);
    intrqst_i = 1'b1;
    wait_ack();
  endtask

  task automatic pop_one();
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
  endtask

  task automatic do_ipi(input logic [13:0] dst);
    cur_dst   = dst;
    ipi_dst_i = dst;
    ipi_req_i = 1'b1;
    tick();
    ipi_req_i = 1'b0;
    chk("ipi_busy_set", ipi_busy_o, 1'b1);
    for (int i = 0; i < 200 && ipi_busy_o; i++) tick();
    if (ipi_busy_o) expired("ipi_wait");
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [15:0] seq [4];
    int d0;
    rst_i = 1'b0; enable_i = 1'b1; halted_i = 1'b1; intrqst_i = 1'b0;
    pi1_rdy_i = 1'b1; pi1_data_i = 16'h0000; irq_ready_i = 1'b0;
    ipi_req_i = 1'b0; ipi_dst_i = '0; cur_dst = '0;
    tick();
    tick();
    chk("rst_op", pi1_op_o, 2'b00);
    chk("rst_data", pi1_data_o, 16'h0000);
    chk("rst_intrdy", intrdy_o, 1'b0);
    chk("rst_intbest", intbest_o, 1'b0);
    chk("rst_valid", irq_valid_o, 1'b0);
    chk("rst_busy", ipi_busy_o, 1'b0);
    chk("rst_done", ipi_done_o, 1'b0);
    chk("rst_err", ipi_err_o, 1'b0);
    rst_i = 1'b1;
    tick();
    chk("intrdy_idle", intrdy_o, 1'b1);
    chk("intbest_halted", intbest_o, 1'b1);
    chk("addr", pi1_addr_o, 15'h0000);
    chk("sel", pi1_sel_o, 2'b11);
    halted_i = 1'b0;
    #1;
    chk("intbest_running", intbest_o, 1'b0);

    // Basic ack returning index 3
    rsp_q.push_back(16'h0003);
    intrqst_i = 1'b1;
    tick();
    chk("t1_op", pi1_op_o, 2'b11);
    chk("t1_data", pi1_data_o, 16'h000C);
    chk("t1_intrdy1", intrdy_o, 1'b0);
    tick();
    chk("t1_noop", pi1_op_o, 2'b00);
    chk("t1_intrdy2", intrdy_o, 1'b0);
    tick();
    chk("t1_valid", irq_valid_o, 1'b1);
    chk("t1_idx", irq_idx_o, 16'h0003);
    chk("t1_noreack", pi1_op_o, 2'b00);
    pop_one();
    chk("t1_popped", irq_valid_o, 1'b0);

    // Spurious result dropped, IPI result queued, disabled core still acks
    do_ack(16'hFFFE);
    chk("t2_discard", irq_valid_o, 1'b0);
    do_ack(16'hFFFF);
    chk("t2_ipi_idx", irq_idx_o, 16'hFFFF);
    pop_one();
    enable_i = 1'b0;
    #1;
    chk("t2_intrdy_dis", intrdy_o, 1'b0);
    do_ack(16'hFFFE);
    enable_i = 1'b1;

    // Fill the queue, defer a fifth request until a pop
    do_ack(16'h000A); do_ack(16'h000B); do_ack(16'h000C); do_ack(16'h000D);
    chk("t3_full_intrdy", intrdy_o, 1'b0);
    chk("t3_head", irq_idx_o, 16'h000A);
    rsp_q.push_back(16'h000E);
    intrqst_i = 1'b1;
    repeat (4) begin
      tick();
      chk("t3_held", pi1_op_o, 2'b00);
    end
    pop_one();
    wait_ack();
    seq = '{16'h000B, 16'h000C, 16'h000D, 16'h000E};
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", irq_idx_o, seq[i]);
      pop_one();
    end
    chk("t3_empty", irq_valid_o, 1'b0);

    // IPI with two busy retries
    d0 = n_done;
    rsp_q.push_back(16'hFFFE); rsp_q.push_back(16'hFFFE); rsp_q.push_back(16'h0002);
    do_ipi(14'd2);
    chk("t4_one_done", n_done, d0 + 1);

    // IPI to 7 returning -1, hand-timed
    d0 = n_done;
    rsp_q.push_back(16'hFFFF);
    cur_dst = 14'd7; ipi_dst_i = 14'd7; ipi_req_i = 1'b1;
    tick();
    ipi_req_i = 1'b0;
    chk("t5_op", pi1_op_o, 2'b11);
    chk("t5_data", pi1_data_o, 16'h001D);
    tick();
    tick();
    chk("t5_done", ipi_done_o, 1'b1);
    chk("t5_err", ipi_err_o, 1'b1);
    chk("t5_busy_clr", ipi_busy_o, 1'b0);
    tick();
    chk("t5_one_done", n_done, d0 + 1);

    // Request arriving during retry wait is acked before the IPI is reissued
    kind_log.delete();
    rsp_q.push_back(16'hFFFE);
    cur_dst = 14'd3; ipi_dst_i = 14'd3; ipi_req_i = 1'b1;
    tick();
    ipi_req_i = 1'b0;
    for (int i = 0; i < 20 && kind_log.size() < 1; i++) tick();
    if (kind_log.size() < 1) expired("t6_first");
    tick(); tick(); tick();
    rsp_q.push_back(16'h0042); rsp_q.push_back(16'h0005);
    intrqst_i = 1'b1;
    for (int i = 0; i < 200 && ipi_busy_o; i++) tick();
    if (ipi_busy_o) expired("t6_ipi");
    tick(); tick();
    chk("t6_nops", kind_log.size(), 3);
    if (kind_log.size() == 3) begin
      chk("t6_ack_first", kind_log[1], 2'b00);
      chk("t6_ipi_after", kind_log[2], 2'b01);
    end
    chk("t6_idx", irq_idx_o, 16'h0042);
    pop_one();

    // Bus stall: op and data stay put
    rsp_q.push_back(16'h0021);
    pi1_rdy_i = 1'b0;
    intrqst_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t7_stall_op", pi1_op_o, 2'b11);
      chk("t7_stall_data", pi1_data_o, 16'h000C);
      tick();
    end
    pi1_rdy_i = 1'b1;
    wait_ack();
    chk("t7_idx", irq_idx_o, 16'h0021);

    // Reset during ACKREQ with the queue non-empty
    rsp_q.push_back(16'h0011);
    pi1_rdy_i = 1'b0;
    intrqst_i = 1'b1;
    tick();
    chk("t8_ackreq", pi1_op_o, 2'b11);
    rst_i = 1'b0;
    tick();
    chk("t8_rst_op", pi1_op_o, 2'b00);
    chk("t8_rst_valid", irq_valid_o, 1'b0);
    rst_i = 1'b1;
    pi1_rdy_i = 1'b1;
    tick();
    chk("t8_reissue", pi1_op_o, 2'b11);
    wait_ack();
    chk("t8_valid", irq_valid_o, 1'b1);
    chk("t8_idx", irq_idx_o, 16'h0011);
    pop_one();
    chk("t8_empty", irq_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
